// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite protocol encodings shared by the SRAM slave and its sub-blocks:
// transfer types, transfer sizes, response codes, the error-response state
// encoding and the little-endian byte-lane decode.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HWORD = 3'b001,
    HSIZE_WORD  = 3'b010
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Response sequencing: ERR1 stalls the bus, ERR2 completes the error.
  typedef enum logic [1:0] {
    RESP_OKAY = 2'b00,
    RESP_ERR1 = 2'b01,
    RESP_ERR2 = 2'b10
  } resp_state_t;

  // Little-endian byte lanes touched by a transfer. Misaligned low address
  // bits are ignored; sizes above a word are treated as a full word.
  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE:  return 4'b0001 << addr_lo;
      HSIZE_HWORD: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram1rw_mem.sv
// Single-port synchronous SRAM: one read or one byte-masked write per cycle.
// A read returns data on the cycle after the enable; rdata holds otherwise.
module sram1rw_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write or full-word synchronous read on the single port.
  // NOTE: the array has no reset; clearing an SRAM on reset is neither
  // possible in a real macro nor needed, so only the control path is reset.
  // NOTE: state is updated with <= so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a single-port synchronous SRAM.
// Zero-wait-state byte/halfword/word reads and writes. Because the SRAM has
// one port, a write whose data phase collides with a new read's address
// phase is parked in a one-entry write buffer and committed on the next free
// cycle; reads of the buffered word merge the buffered bytes into HRDATA.
// Build option: define AHB_ERROR_EN to answer out-of-range addresses
// (HADDR >= MEM_SIZE) with a two-cycle ERROR; otherwise addresses wrap.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int IW    = AW - 2;
  localparam int DEPTH = MEM_SIZE / 4;

  // Address phase decode
  logic          accept;
  logic          addr_err;
  logic          mem_acc;
  logic          rd_req;
  logic [IW-1:0] ap_idx;
  logic [3:0]    ap_be;

  // Data phase pipeline registers
  logic          dp_valid;
  logic          dp_write;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_be;
  logic          wr_commit;
  logic          rd_dp;

  // Posted write buffer
  logic          buf_valid;
  logic [IW-1:0] buf_idx;
  logic [3:0]    buf_be;
  logic [31:0]   buf_data;

  // SRAM port
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [IW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  // Read return path
  logic          fwd_hit;
  logic [31:0]   rdata_fwd;
  logic [31:0]   rdata_hold;

  resp_state_t   state_q, state_d;

  assign accept  = HSEL && HREADY &&
                   (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign ap_idx  = HADDR[AW-1:2];
  assign ap_be   = byte_enables(HSIZE, HADDR[1:0]);
  assign mem_acc = accept && !addr_err;
  assign rd_req  = mem_acc && !HWRITE;

  logic unused_inputs;
`ifdef AHB_ERROR_EN
  assign addr_err      = |HADDR[HADDR_SIZE-1:AW];
  assign unused_inputs = ^{HBURST, HPROT};
`else
  assign addr_err      = 1'b0;
  assign unused_inputs = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:AW]};
`endif

  // Capture the accepted transfer for its data phase; hold while the bus stalls.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
    end else if (HREADY) begin
      dp_valid <= mem_acc;
      dp_write <= HWRITE;
      dp_idx   <= ap_idx;
      dp_be    <= ap_be;
    end
  end

  assign wr_commit = dp_valid && dp_write && HREADY;
  assign rd_dp     = dp_valid && !dp_write;

  // SRAM port arbitration: new read, then buffered write, then direct write.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = ap_idx;
    sram_wdata = HWDATA;
    if (rd_req) begin
      sram_en = 1'b1;
    end else if (buf_valid) begin
      sram_en    = 1'b1;
      sram_we    = buf_be;
      sram_addr  = buf_idx;
      sram_wdata = buf_data;
    end else if (wr_commit) begin
      sram_en    = 1'b1;
      sram_we    = dp_be;
      sram_addr  = dp_idx;
      sram_wdata = HWDATA;
    end
  end

  // Park a write that lost the port; drain the buffer on the next free cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_be    <= '0;
      buf_data  <= '0;
    end else if (wr_commit && (rd_req || buf_valid)) begin
      buf_valid <= 1'b1;
      buf_idx   <= dp_idx;
      buf_be    <= dp_be;
      buf_data  <= HWDATA;
    end else if (buf_valid && !rd_req) begin
      buf_valid <= 1'b0;
    end
  end

  sram1rw_mem #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_mem (
    .clk   (HCLK),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  // Merge not-yet-committed buffered bytes of the same word over SRAM data.
  always_comb begin
    fwd_hit   = buf_valid && (buf_idx == dp_idx);
    rdata_fwd = sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit && buf_be[i]) rdata_fwd[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

  // Keep the last returned read word so HRDATA holds through writes and idles.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rdata_hold <= '0;
    end else if (rd_dp && HREADY) begin
      rdata_hold <= rdata_fwd;
    end
  end

  assign HRDATA = rd_dp ? rdata_fwd : rdata_hold;

  // Response state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= RESP_OKAY;
    else        state_q <= state_d;
  end

  // Response sequencing and bus handshake outputs.
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      RESP_ERR1: begin
        state_d   = RESP_ERR2;
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      RESP_ERR2: begin
        state_d = (accept && addr_err) ? RESP_ERR1 : RESP_OKAY;
        HRESP   = HRESP_ERROR;
      end
      default: begin
        state_d = (accept && addr_err) ? RESP_ERR1 : RESP_OKAY;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Scoreboard bench for ahb3lite_sram_slave: a driver issues directed AHB
// transfers and queues the expected data-phase response; a monitor on the
// falling edge follows the bus pipeline and checks every cycle.
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

  localparam int MEM_SIZE = 4096;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;

  ahb3lite_sram_slave #(
    .MEM_SIZE   (MEM_SIZE),
    .HADDR_SIZE (32),
    .HDATA_SIZE (32)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  // Single slave on the bus: its ready is the bus ready.
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          is_read;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] pend_wdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
  endtask

  // ---------------- monitor ----------------
  bit          dp_active = 1'b0;
  bit          have_cur  = 1'b0;
  bit          err_first = 1'b0;
  exp_t        cur;
  logic [31:0] last_rd = 32'h0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      check("reset_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      check("reset_hresp",     {31'b0, HRESP},     32'd0);
      check("reset_hrdata",    HRDATA,             32'h0);
      dp_active = 1'b0;
      have_cur  = 1'b0;
      last_rd   = 32'h0;
    end else begin
      if (dp_active) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_data_phase: no queued response at %0t", $time);
            cur = '{is_read: 1'b0, err: 1'b0, data: 32'h0};
          end else begin
            cur = exp_q.pop_front();
          end
          have_cur  = 1'b1;
          err_first = 1'b0;
        end
        if (cur.err && !err_first) begin
          check("err1_hreadyout", {31'b0, HREADYOUT}, 32'd0);
          check("err1_hresp",     {31'b0, HRESP},     32'd1);
          err_first = 1'b1;
        end else begin
          check("dp_hreadyout", {31'b0, HREADYOUT}, 32'd1);
          check("dp_hresp",     {31'b0, HRESP},     {31'b0, cur.err});
          if (!cur.err) begin
            if (cur.is_read) begin
              check("read_hrdata", HRDATA, cur.data);
              last_rd = cur.data;
            end else begin
              check("write_hold_hrdata", HRDATA, last_rd);
            end
          end
          have_cur = 1'b0;
        end
      end else begin
        check("idle_hreadyout", {31'b0, HREADYOUT}, 32'd1);
        check("idle_hresp",     {31'b0, HRESP},     32'd0);
        check("idle_hold_hrdata", HRDATA, last_rd);
      end
      if (HREADY) dp_active = HSEL && HTRANS[1];
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic sel, input logic [1:0] trans, input logic write,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err);
    int n;
    HWDATA = pend_wdata;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = write;
    HSIZE  = size;
    HADDR  = addr;
    HBURST = 3'b000;
    HPROT  = 4'b0011;
    pend_wdata = write ? wdata : 32'hDEAD_BEEF;
    if (sel && trans[1]) exp_q.push_back('{is_read: !write, err: exp_err, data: exp_rd});
    // The address phase ends at the first rising edge that sees HREADY high.
    n = 0;
    @(negedge HCLK);
    while (!HREADY && n < 16) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 16) begin
      checks++;
      $display("FAIL hready_timeout: HREADY low for %0d cycles, required high", n);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
    issue(1'b1, HTRANS_NONSEQ, 1'b1, size, addr, data, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] exp_rd);
    issue(1'b1, HTRANS_NONSEQ, 1'b0, size, addr, 32'h0, exp_rd, 1'b0);
  endtask

  task automatic idle();
    issue(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    HADDR  = 32'h0;
    HWDATA = 32'h0;
    HBURST = 3'b000;
    HPROT  = 4'b0011;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Word write, back-to-back readback (forwarded), then readback from SRAM.
    wr(HSIZE_WORD, 32'h10, 32'h1234_5678);
    rd(HSIZE_WORD, 32'h10, 32'h1234_5678);
    idle();
    rd(HSIZE_WORD, 32'h10, 32'h1234_5678);

    // Byte write into lane 1; other HWDATA lanes must be ignored.
    wr(HSIZE_BYTE, 32'h11, 32'h5A5A_AB5A);
    idle();
    rd(HSIZE_WORD, 32'h10, 32'h1234_AB78);
    rd(HSIZE_BYTE, 32'h13, 32'h1234_AB78);

    // Halfword to upper lanes, immediate read merges with SRAM lower half.
    wr(HSIZE_WORD, 32'h20, 32'h0000_0000);
    idle();
    wr(HSIZE_HWORD, 32'h22, 32'hCAFE_1111);
    rd(HSIZE_WORD, 32'h20, 32'hCAFE_0000);

    // Misaligned halfword (bit 0 ignored), back-to-back write/write/read.
    wr(HSIZE_WORD, 32'h30, 32'hDDCC_BBAA);
    wr(HSIZE_HWORD, 32'h31, 32'h0000_9876);
    rd(HSIZE_BYTE, 32'h33, 32'hDDCC_9876);

    // IDLE/BUSY with HSEL=1 and an unselected NONSEQ must not touch memory.
    issue(1'b1, HTRANS_IDLE,   1'b1, HSIZE_WORD, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(1'b1, HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    idle();
    rd(HSIZE_WORD, 32'h10, 32'h1234_AB78);

    // Interleaved write/read chain exercising the posted write buffer.
    wr(HSIZE_WORD, 32'h40, 32'h1111_1111);
    rd(HSIZE_WORD, 32'h40, 32'h1111_1111);
    wr(HSIZE_WORD, 32'h44, 32'h2222_2222);
    rd(HSIZE_WORD, 32'h44, 32'h2222_2222);
    rd(HSIZE_WORD, 32'h40, 32'h1111_1111);
    idle();
    issue(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h44, 32'h0, 32'h2222_2222, 1'b0);

    // HSIZE above word acts as an aligned word.
    wr(3'b011, 32'h52, 32'hA5A5_A5A5);
    idle();
    rd(HSIZE_WORD, 32'h50, 32'hA5A5_A5A5);

`ifndef AHB_ERROR_EN
    // Out-of-range address wraps modulo MEM_SIZE.
    wr(HSIZE_WORD, MEM_SIZE + 32'h60, 32'h6060_6060);
    idle();
    rd(HSIZE_WORD, 32'h60, 32'h6060_6060);
`endif

    // Reset during a write data phase drops the write.
    wr(HSIZE_WORD, 32'h70, 32'h7777_7777);
    idle();
    HWDATA = pend_wdata;
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HWRITE = 1'b1;
    HSIZE  = HSIZE_WORD;
    HADDR  = 32'h70;
    @(posedge HCLK);
    #1;
    HWDATA = 32'h8888_8888;
    HRESET = 1'b1;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    pend_wdata = 32'h0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    idle();
    rd(HSIZE_WORD, 32'h70, 32'h7777_7777);
    rd(HSIZE_WORD, 32'h10, 32'h1234_AB78);

`ifdef AHB_ERROR_EN
    // Out-of-range read gets the two-cycle ERROR; next transfer is OKAY.
    issue(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, MEM_SIZE, 32'h0, 32'h0, 1'b1);
    rd(HSIZE_WORD, 32'h10, 32'h1234_AB78);
    // Out-of-range write must not alias onto word 0x10.
    issue(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, MEM_SIZE + 32'h10, 32'hBAD0_BAD0, 32'h0, 1'b1);
    idle();
    idle();
    rd(HSIZE_WORD, 32'h10, 32'h1234_AB78);
`endif

    repeat (3) idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
